muldiv_hilo_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS core.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_hilo_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_hilo_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
//
// state  | meaning
// S_IDLE | waiting for Start; MTHI/MTLO accepted
// S_MUL  | one shift-add step per cycle on |A| * |B|
// S_DIV  | one restoring step per cycle on |A| / |B|
// S_FIX  | sign correction, HI/LO write, Done pulse
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_orig_q, a_orig_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_by_zero_q, div_by_zero_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_acc;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;

    always_comb begin
        sign_a = ~Op[0] & A[WIDTH-1];
        sign_b = ~Op[0] & B[WIDTH-1];
        abs_a  = sign_a ? -A : A;
        abs_b  = sign_b ? -B : B;

        // Multiplier sits in the low half and shifts out as the product shifts in.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, m_q};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, m_q}) : div_shift[WIDTH-1:0];
        div_acc   = {div_rem, acc_q[WIDTH-2:0], div_ge};

        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        m_d           = m_q;
        a_orig_d      = a_orig_q;
        neg_d         = neg_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        is_div_d      = is_div_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d   = Op[1] ? S_DIV : S_MUL;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(WIDTH);
                    m_d       = Op[1] ? abs_b : abs_a;
                    acc_d     = {{WIDTH{1'b0}}, (Op[1] ? abs_a : abs_b)};
                    a_orig_d  = A;
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    dbz_d     = Op[1] & (B == '0);
                    is_div_d  = Op[1];
                end else begin
                    if (MTHI) hi_d = WrData;
                    if (MTLO) lo_d = WrData;
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_DIV) ? div_acc : mul_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dbz_q) begin
                    hi_d          = a_orig_q;
                    lo_d          = '1;
                    div_by_zero_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            m_q           <= '0;
            a_orig_q      <= '0;
            neg_q         <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            is_div_q      <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            m_q           <= m_d;
            a_orig_q      <= a_orig_d;
            neg_q         <= neg_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            is_div_q      <= is_div_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = div_by_zero_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed vector bench for muldiv_hilo_unit at WIDTH=32.
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             Start = 1'b0;
    logic [1:0]       Op = 2'b00;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             MTHI = 1'b0;
    logic             MTLO = 1'b0;
    logic [WIDTH-1:0] WrData = '0;
    logic             Busy, Done, DivByZero;
    logic [WIDTH-1:0] HI, LO;

    muldiv_hilo_unit #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .MTHI(MTHI), .MTLO(MTLO), .WrData(WrData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b, hi, lo;
        logic             dbz;
    } vec_t;

    vec_t vecs[14];

    // Launches one operation and watches it until Done. When disturb is set,
    // MTHI rides along with Start, and a second Start+MTHI is pulsed mid-flight.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit disturb,
                          output logic [WIDTH-1:0] hi, output logic [WIDTH-1:0] lo, output logic dbz,
                          output int lat, output int busy_cnt, output bit hold_ok, output bit busy_at_done);
        logic [WIDTH-1:0] hi0, lo0;
        int n;
        @(negedge Clk);
        Op = op; A = a; B = b; Start = 1'b1;
        MTHI = disturb; WrData = 32'hDEADBEEF;
        hi0 = HI; lo0 = LO;
        @(posedge Clk);
        n = 0; busy_cnt = 0; lat = -1; hold_ok = 1'b1; busy_at_done = 1'b0;
        hi = '0; lo = '0; dbz = 1'b0;
        while (n < 100) begin
            @(negedge Clk);
            Start = 1'b0; MTHI = 1'b0; A = ~a; B = ~b;
            if (disturb && n == 5) begin
                Start = 1'b1; MTHI = 1'b1; Op = OP_MULTU; A = 32'd99; B = 32'd99;
            end
            if (Done) begin
                lat = n; hi = HI; lo = LO; dbz = DivByZero; busy_at_done = Busy;
                break;
            end
            if (Busy) busy_cnt++;
            if (HI !== hi0 || LO !== lo0 || DivByZero !== 1'b0) hold_ok = 1'b0;
            @(posedge Clk);
            n++;
        end
        Start = 1'b0; MTHI = 1'b0;
    endtask

    logic [WIDTH-1:0] r_hi, r_lo;
    logic r_dbz;
    int r_lat, r_busy;
    bit r_hold, r_bad;
    bit done_seen;

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{OP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[12] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        vecs[13] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_dbz", 64'(DivByZero), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        Reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r_hi, r_lo, r_dbz, r_lat, r_busy, r_hold, r_bad);
            check($sformatf("v%0d_hi", i), 64'(r_hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(r_lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_dbz", i), 64'(r_dbz), 64'(vecs[i].dbz));
            check($sformatf("v%0d_latency", i), 64'(r_lat), 64'(LAT));
            check($sformatf("v%0d_busy_cycles", i), 64'(r_busy), 64'(LAT));
            check($sformatf("v%0d_hold", i), 64'(r_hold), 64'd1);
            check($sformatf("v%0d_busy_at_done", i), 64'(r_bad), 64'd0);
            @(negedge Clk);
            check($sformatf("v%0d_pulse_end", i), {61'd0, Done, DivByZero, Busy}, 64'd0);
        end

        // MT writes while idle, one at a time and then both together.
        @(negedge Clk);
        MTHI = 1'b1; WrData = 32'hAAAA0000;
        @(negedge Clk);
        MTHI = 1'b0; MTLO = 1'b1; WrData = 32'h00005555;
        @(negedge Clk);
        MTLO = 1'b0;
        check("mt_hi", 64'(HI), 64'h00000000AAAA0000);
        check("mt_lo", 64'(LO), 64'h0000000000005555);
        MTHI = 1'b1; MTLO = 1'b1; WrData = 32'h0BADF00D;
        @(negedge Clk);
        MTHI = 1'b0; MTLO = 1'b0;
        check("mt_both_hi", 64'(HI), 64'h000000000BADF00D);
        check("mt_both_lo", 64'(LO), 64'h000000000BADF00D);

        // Start beats a simultaneous MTHI; Start/MTHI during Busy are ignored.
        run_op(OP_MULTU, 32'd3, 32'd4, 1'b1, r_hi, r_lo, r_dbz, r_lat, r_busy, r_hold, r_bad);
        check("dist_hi", 64'(r_hi), 64'd0);
        check("dist_lo", 64'(r_lo), 64'h0C);
        check("dist_latency", 64'(r_lat), 64'(LAT));
        check("dist_hold", 64'(r_hold), 64'd1);
        r_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Busy || Done) r_busy++;
        end
        check("dist_no_restart", 64'(r_busy), 64'd0);
        check("dist_final_lo", 64'(LO), 64'h0C);

        // Reset in the middle of an operation aborts it with no Done.
        @(negedge Clk);
        Op = OP_MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge Clk);
            if (c == 2) Reset = 1'b1;
            if (Done || Busy) done_seen = 1'b1;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, r_hi, r_lo, r_dbz, r_lat, r_busy, r_hold, r_bad);
        check("post_abort_hi", 64'(r_hi), 64'd0);
        check("post_abort_lo", 64'(r_lo), 64'd3);
        check("post_abort_latency", 64'(r_lat), 64'(LAT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
